// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl: BHT/BTB initialisation sweep, queued branch-update writer and mispredict flush generator
module bpu_update_ctrl #(
   parameter int BHT_SIZE   = 64,
   parameter int IDX_W      = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_valid_D,
   output logic             upd_ready_D,
   input  logic [31:0]      PC_D,
   input  logic             PC_src_D,
   input  logic [31:0]      real_target,
   input  logic             pred_jump_D,
   input  logic [31:0]      pred_target_D,
   input  logic             clear_req,
   output logic             tbl_we,
   output logic [IDX_W-1:0] tbl_idx,
   output logic [1:0]       tbl_bht_wdata,
   input  logic [1:0]       tbl_bht_rdata,
   output logic             tbl_btb_we,
   output logic [31:0]      tbl_btb_wdata,
   output logic             mispredict,
   output logic [31:0]      redirect_pc,
   output logic             busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BHT_SIZE - 1);

   typedef enum logic {SWEEP, RUN} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] sweep_idx, sweep_nx;
   logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
   logic             q_tk  [FIFO_DEPTH];
   logic [31:0]      q_tgt [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             push, pop, mismatch;
   logic [1:0]       bht_inc, bht_dec;

   // Ready looks only at registered occupancy so a full queue never relies on a same-cycle pop
   assign upd_ready_D = !rst && state == RUN && count != FULL;
   assign push        = upd_valid_D && upd_ready_D;
   assign busy        = rst || state == SWEEP;
   assign mismatch    = (PC_src_D != pred_jump_D) || (PC_src_D && pred_jump_D && pred_target_D != real_target);
   assign bht_inc     = tbl_bht_rdata == 2'b11 ? 2'b11 : tbl_bht_rdata + 2'd1;
   assign bht_dec     = tbl_bht_rdata == 2'b00 ? 2'b00 : tbl_bht_rdata - 2'd1;

   // State and sweep index register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SWEEP;
         sweep_idx <= '0;
      end else begin
         state     <= state_nx;
         sweep_idx <= sweep_nx;
      end
   end

   // Next state and table port: sweep writes, queue-head update, or idle; clear drops the head unwritten
   always_comb begin
      state_nx      = state;
      sweep_nx      = sweep_idx;
      pop           = 1'b0;
      tbl_we        = 1'b0;
      tbl_btb_we    = 1'b0;
      tbl_idx       = '0;
      tbl_bht_wdata = 2'b01;
      tbl_btb_wdata = '0;
      if (state == SWEEP) begin
         tbl_we     = 1'b1;
         tbl_btb_we = 1'b1;
         tbl_idx    = sweep_idx;
         sweep_nx   = clear_req ? '0 : sweep_idx + 1'b1;
         state_nx   = (!clear_req && sweep_idx == LAST) ? RUN : SWEEP;
      end else if (clear_req) begin
         state_nx = SWEEP;
         sweep_nx = '0;
      end else if (count != '0) begin
         pop           = 1'b1;
         tbl_we        = 1'b1;
         tbl_idx       = q_idx[rd_ptr];
         tbl_bht_wdata = q_tk[rd_ptr] ? bht_inc : bht_dec;
         tbl_btb_we    = q_tk[rd_ptr];
         tbl_btb_wdata = q_tgt[rd_ptr];
      end
      if (rst) begin
         pop        = 1'b0;
         tbl_we     = 1'b0;
         tbl_btb_we = 1'b0;
      end
   end

   // Queue storage; contents are don't-care until pointed at, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         q_idx[wr_ptr] <= PC_D[IDX_W+1:2];
         q_tk[wr_ptr]  <= PC_src_D;
         q_tgt[wr_ptr] <= real_target;
      end
   end

   // Queue pointers and occupancy; clear empties the queue, discarding anything accepted this cycle
   always_ff @(posedge clk) begin
      if (rst || clear_req) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + CW'(push) - CW'(pop);
      end
   end

   // Mispredict pulse the cycle after an accepted mismatching branch; redirect holds between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         mispredict <= push && mismatch;
         if (push && mismatch)
            redirect_pc <= PC_src_D ? real_target : PC_D + 32'd4;
      end
   end
endmodule

// File: tb/tb_bpu_update_ctrl.sv
// tb_bpu_update_ctrl: randomized and directed checks of bpu_update_ctrl against a queue-based reference model
module tb_bpu_update_ctrl;
   localparam int N = 64;
   localparam int IW = 6;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, upd_valid_D, upd_ready_D, PC_src_D, pred_jump_D, clear_req;
   logic          tbl_we, tbl_btb_we, mispredict, busy;
   logic [31:0]   PC_D, real_target, pred_target_D, tbl_btb_wdata, redirect_pc;
   logic [IW-1:0] tbl_idx;
   logic [1:0]    tbl_bht_wdata, tbl_bht_rdata;
   logic [1:0]    mem [N];

   always @(posedge clk) if (tbl_we) mem[tbl_idx] <= tbl_bht_wdata;
   assign tbl_bht_rdata = mem[tbl_idx];

   bpu_update_ctrl #(.BHT_SIZE(N), .IDX_W(IW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .upd_valid_D(upd_valid_D), .upd_ready_D(upd_ready_D),
      .PC_D(PC_D), .PC_src_D(PC_src_D), .real_target(real_target),
      .pred_jump_D(pred_jump_D), .pred_target_D(pred_target_D), .clear_req(clear_req),
      .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_bht_wdata(tbl_bht_wdata),
      .tbl_bht_rdata(tbl_bht_rdata), .tbl_btb_we(tbl_btb_we), .tbl_btb_wdata(tbl_btb_wdata),
      .mispredict(mispredict), .redirect_pc(redirect_pc), .busy(busy)
   );

   typedef struct {int idx; bit tk; logic [31:0] tgt;} upd_t;

   upd_t        q[$];
   bit          m_run;
   int          m_sw;
   int          m_bht [N];
   bit          m_mis;
   logic [31:0] m_red;
   int          n_vec, n_bad;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(int v, bit tk);
      return tk ? (v == 3 ? 3 : v + 1) : (v == 0 ? 0 : v - 1);
   endfunction

   task automatic step(bit r, bit c, bit v, logic [31:0] pc, bit tk, logic [31:0] tgt, bit pj, logic [31:0] pt);
      upd_t h;
      bit   rdy, push;
      @(negedge clk);
      rst = r; clear_req = c; upd_valid_D = v; PC_D = pc; PC_src_D = tk;
      real_target = tgt; pred_jump_D = pj; pred_target_D = pt;
      #1;
      rdy = m_run && q.size() < DEPTH;
      if (r) begin
         chk("rst_we", 32'(tbl_we), 0);
         chk("rst_btb_we", 32'(tbl_btb_we), 0);
         chk("rst_busy", 32'(busy), 1);
      end else if (!m_run) begin
         chk("sw_busy", 32'(busy), 1);
         chk("sw_ready", 32'(upd_ready_D), 0);
         chk("sw_we", 32'(tbl_we), 1);
         chk("sw_btb_we", 32'(tbl_btb_we), 1);
         chk("sw_idx", 32'(tbl_idx), 32'(m_sw));
         chk("sw_wdata", 32'(tbl_bht_wdata), 1);
         chk("sw_btb_wdata", tbl_btb_wdata, 0);
      end else begin
         chk("run_busy", 32'(busy), 0);
         chk("run_ready", 32'(upd_ready_D), 32'(rdy));
         if (!c && q.size() > 0) begin
            h = q[0];
            chk("pop_we", 32'(tbl_we), 1);
            chk("pop_idx", 32'(tbl_idx), 32'(h.idx));
            chk("pop_wdata", 32'(tbl_bht_wdata), 32'(sat(m_bht[h.idx], h.tk)));
            chk("pop_btb_we", 32'(tbl_btb_we), 32'(h.tk));
            if (h.tk) chk("pop_btb_wdata", tbl_btb_wdata, h.tgt);
         end else begin
            chk("idle_we", 32'(tbl_we), 0);
            chk("idle_btb_we", 32'(tbl_btb_we), 0);
            if (!c) chk("idle_idx", 32'(tbl_idx), 0);
         end
      end
      chk("mispredict", 32'(mispredict), 32'(m_mis));
      chk("redirect_pc", redirect_pc, m_red);
      push = v && rdy && !r;
      if (r) begin
         m_run = 0; m_sw = 0; q.delete(); m_mis = 0; m_red = 0;
      end else begin
         m_mis = push && ((tk != pj) || (tk && pj && pt != tgt));
         if (m_mis) m_red = tk ? tgt : pc + 32'd4;
         if (!m_run) begin
            m_bht[m_sw] = 1;
            if (c) m_sw = 0;
            else if (m_sw == N - 1) begin m_run = 1; m_sw = 0; end
            else m_sw++;
         end else if (c) begin
            q.delete(); m_run = 0; m_sw = 0;
         end else begin
            if (q.size() > 0) begin
               h = q.pop_front();
               m_bht[h.idx] = sat(m_bht[h.idx], h.tk);
            end
            if (push) q.push_back('{idx: int'(pc[IW+1:2]), tk: tk, tgt: tgt});
         end
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] pc, tgt, pt;
      bit          tk, pj;
      n_vec = 0; n_bad = 0;
      m_run = 0; m_sw = 0; m_mis = 0; m_red = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(N + 2);
      step(0, 0, 1, 32'h104, 1, 32'h200, 1, 32'h200);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("dir_idx", 32'(tbl_idx), 1);
      chk("dir_wdata", 32'(tbl_bht_wdata), 2);
      chk("dir_btb", tbl_btb_wdata, 32'h200);
      step(0, 0, 1, 32'h104, 1, 32'h200, 1, 32'h300);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("dir_mis_tgt", redirect_pc, 32'h200);
      step(0, 0, 1, 32'h1fc, 0, 32'h500, 1, 32'h500);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("dir_mis_nt", redirect_pc, 32'h200);
      step(0, 0, 1, 32'hffff_fffc, 0, 32'h10, 1, 32'h10);
      idle(2);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 32'h100 + 32'(i % 3) * 4, i[0], 32'h40 * 32'(i), 0, 0);
      step(0, 0, 1, 32'h108, 1, 32'h77, 1, 32'h77);
      step(0, 1, 1, 32'h108, 1, 32'h77, 1, 32'h77);
      for (int i = 0; i < 40 && m_sw != 30; i++) idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(N + 4);
      for (int i = 0; i < 4000; i++) begin
         tk  = 1'($urandom);
         pj  = 1'($urandom);
         pc  = $urandom_range(0, 3) == 0 ? ($urandom & 32'hffff_fffc) : 32'h100 + 32'($urandom_range(0, 7)) * 4;
         tgt = $urandom & 32'hffff_fffc;
         pt  = $urandom_range(0, 2) == 0 ? ($urandom & 32'hffff_fffc) : tgt;
         step($urandom_range(0, 499) == 0, $urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, pc, tk, tgt, pj, pt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/bpu_update_ctrl.md
BPU_UPDATE_CTRL -- requirements
Module: bpu_update_ctrl

Interface
REQ-001 Parameter BHT_SIZE, default 64: number of BHT/BTB entries; power of two, 4..256.
REQ-002 Parameter IDX_W, default 6: table index width; equals log2(BHT_SIZE).
REQ-003 Parameter FIFO_DEPTH, default 2: update queue depth; power of two, 2..8.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 upd_valid_D  in  1  decode stage presents a resolved branch.
REQ-007 upd_ready_D  out  1  controller accepts the update this cycle.
REQ-008 PC_D  in  32  PC of the resolved branch.
REQ-009 PC_src_D  in  1  actual taken flag.
REQ-010 real_target  in  32  actual taken target.
REQ-011 pred_jump_D  in  1  taken prediction made in IF for this branch.
REQ-012 pred_target_D  in  32  target predicted in IF for this branch.
REQ-013 clear_req  in  1  request to re-initialise both tables.
REQ-014 tbl_we  out  1  BHT write strobe.
REQ-015 tbl_idx  out  IDX_W  table read/write index.
REQ-016 tbl_bht_wdata  out  2  BHT write data.
REQ-017 tbl_bht_rdata  in  2  BHT entry at tbl_idx, combinational read.
REQ-018 tbl_btb_we  out  1  BTB write strobe.
REQ-019 tbl_btb_wdata  out  32  BTB write data.
REQ-020 mispredict  out  1  one-cycle flush pulse to IF/D.
REQ-021 redirect_pc  out  32  correct next PC; valid while mispredict=1.
REQ-022 busy  out  1  table sweep in progress; IF treats prediction as not-taken.

Function
REQ-023 States: SWEEP, RUN. Reset enters SWEEP with sweep index 0.
REQ-024 SWEEP, one entry per cycle: tbl_we=1, tbl_btb_we=1, tbl_idx=sweep index, tbl_bht_wdata=2'b01, tbl_btb_wdata=0.
REQ-025 SWEEP lasts exactly BHT_SIZE cycles. The cycle after index BHT_SIZE-1 is written, the block is in RUN. busy=1 throughout SWEEP.
REQ-026 upd_ready_D = (state==RUN) and queue not full; push occurs only when valid and ready. Ready does not depend on a same-cycle pop.
REQ-027 Queue entry: {PC_D[IDX_W+1:2], PC_src_D, real_target}; FIFO order; circular pointers wrap modulo FIFO_DEPTH.
REQ-028 RUN, queue non-empty: pop the head each cycle, tbl_idx=head index, tbl_we=1.
REQ-029 Saturating update from tbl_bht_rdata. Taken: 00->01, 01->10, 10->11, 11->11. Not-taken: 11->10, 10->01, 01->00, 00->00.
REQ-030 On pop, tbl_btb_we = head taken flag and tbl_btb_wdata = head target.
REQ-031 RUN, queue empty: tbl_we=0, tbl_btb_we=0, tbl_idx=0.
REQ-032 Same-cycle push and pop are both performed. A push into an empty queue is popped no earlier than the next cycle.
REQ-033 Back-to-back pops to the same index are correct, because the table write lands before the next combinational read.
REQ-034 Mispredict is evaluated on each accepted push and registered, so mispredict=1 the cycle after acceptance.
REQ-035 A mismatch is (PC_src_D != pred_jump_D) or (PC_src_D and pred_jump_D and pred_target_D != real_target).
REQ-036 redirect_pc = real_target if taken, else PC_D+4 (mod 2^32). redirect_pc holds its last value when mispredict=0.
REQ-037 clear_req=1 in RUN: the next cycle is SWEEP index 0, the queue is emptied, and pending updates are discarded.
REQ-038 clear_req=1 during SWEEP restarts the sweep at index 0 the next cycle.
REQ-039 rst has priority over clear_req and over all other inputs.

Reset
REQ-040 rst=1 for one or more cycles, at any time including mid-SWEEP or with the queue non-empty. Next state: SWEEP index 0, queue empty, mispredict=0, redirect_pc=0, upd_ready_D=0.
REQ-041 While rst=1, outputs are forced: tbl_we=0, tbl_btb_we=0, busy=1.

Verification
REQ-042 Release rst, then count cycles. Required: 64 consecutive writes at idx 0..63 with data 01/0, busy=1 for exactly 64 cycles, upd_ready_D=1 on cycle 65.
REQ-043 RUN, push PC_D=0x104 taken, target 0x200, rdata=01. Required: next cycle tbl_idx=1, tbl_bht_wdata=10, tbl_btb_we=1, tbl_btb_wdata=0x200.
REQ-044 Push with pred_jump_D=1, pred_target_D=0x300, PC_src_D=1, real_target=0x200. Required: mispredict=1 for one cycle with redirect_pc=0x200. A not-taken branch at PC 0x1FC predicted taken gives redirect_pc=0x200.
REQ-045 Hold upd_valid_D=1 continuously, with the table side able to absorb one pop per cycle. Required: no queue overflow and updates in FIFO order; with FIFO_DEPTH=2, upd_ready_D falls only when the queue is full.
REQ-046 Assert clear_req with the queue holding 2 entries. Required: those updates are never written, and a 64-cycle sweep starts at idx 0.
REQ-047 Assert rst on sweep index 30. Required: the sweep restarts at 0 and completes a full 64 entries.
